// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide: shift-add multiply and restoring divide on magnitudes,
// with sign correction applied once in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivByZero
);

    localparam logic [5:0] LastIter = 6'(MDU_ITERS - 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    mdu_op_e          start_op;
    logic             start_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign start_op     = mdu_op_e'(Op);
    assign start_signed = op_is_signed(start_op);

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (
        .in_i  (A),
        .neg_i (start_signed & A[WIDTH-1]),
        .out_o (abs_a)
    );

    mdu_sign_fix #(.W(WIDTH)) u_abs_b (
        .in_i  (B),
        .neg_i (start_signed & B[WIDTH-1]),
        .out_o (abs_b)
    );

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic               unused_div_bit;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_trial} - {2'b00, opnd_q};
    assign div_next  = div_diff[WIDTH+1] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    // A kept difference is below the divisor, so its top bit is always clear.
    assign unused_div_bit = div_diff[WIDTH];

    logic               res_signed;
    logic               res_is_div;
    logic               neg_result;
    logic               div_zero;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign res_signed = op_is_signed(op_q);
    assign res_is_div = op_is_div(op_q);
    assign neg_result = res_signed & (sign_a_q ^ sign_b_q);
    assign div_zero   = (opnd_q == '0);

    mdu_sign_fix #(.W(2 * WIDTH)) u_fix_prod (
        .in_i  (acc_q),
        .neg_i (neg_result),
        .out_o (prod_fixed)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
        .in_i  (acc_q[WIDTH-1:0]),
        .neg_i (neg_result),
        .out_o (quo_fixed)
    );

    // Remainder takes the dividend's sign.
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .in_i  (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (res_signed & sign_a_q),
        .out_o (rem_fixed)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d     = start_op;
                    sign_a_d = A[WIDTH-1];
                    sign_b_d = B[WIDTH-1];
                    a_raw_d  = A;
                    if (op_is_div(start_op)) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = res_is_div ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LastIter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (res_is_div) begin
                    if (div_zero) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fixed;
                        lo_d = quo_fixed;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fixed;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign DivByZero = dbz_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the multicycle datapath; the result source that feeds the per-cycle ALU result capture register and the HI/LO read path.
- Accepts one operation on a Start pulse and computes it over a fixed number of cycles.
- Presents a 64-bit result on HI/LO and pulses Done for one cycle.
- The control FSM stalls on Busy.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits. Only 32 is verified.

Ports:
- CLK  input  1  clock; rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse; HI/LO are valid from this cycle on.
- HI  output  WIDTH  product[63:32] / remainder.
- LO  output  WIDTH  product[31:0] / quotient.
- DivByZero  output  1  set with Done for DIV/DIVU when B==0; held until the next Start is accepted.

Behaviour:
- Clock and reset: one clock (CLK); reset (Reset) is asynchronous and active-high.
- Reset, including mid-operation:
  - state=IDLE; Busy=0, Done=0, DivByZero=0, HI=0, LO=0.
  - Any in-flight operation is discarded.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- Start accepted in IDLE (edge N):
  - Latch Op and operand sign bits.
  - Load |A| and |B| (signed ops) or raw A and B (unsigned ops).
  - Clear the 6-bit iteration counter; go to CALC.
  - Clear DivByZero.
- CALC: one iteration per cycle, 32 iterations (edges N+1..N+32); counter 31 -> go to FIX.
  - Multiply: shift-add on a 64-bit accumulator {P, multiplier}; adds use a 33-bit carry.
  - Divide: restoring, 33-bit trial subtract of {rem, next dividend bit} minus divisor. Non-negative result keeps the difference and shifts in quotient bit 1; otherwise shifts in 0.
- FIX (edge N+33): apply the sign correction and write HI/LO; go to DONE.
  - MULT: negate the 64-bit product if sign(A)^sign(B).
  - DIV: negate quotient if sign(A)^sign(B); negate remainder if sign(A) (remainder takes dividend sign).
  - Divide by zero, either signedness: HI=A (raw input), LO=all ones, DivByZero=1. Overrides the sign fix.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No flag; this falls out of magnitude math.
- DONE: Done=1 for exactly this cycle; go to IDLE at edge N+34.
- Latency: Start at edge N gives Done high between edges N+33 and N+34. The next Start is accepted no earlier than edge N+34.
- Start while Busy: ignored; no queuing, no effect on the operation in flight.
- Operand inputs are don't-care after edge N.
- HI/LO change only in FIX; otherwise hold the last result.

Decomposition:
- Shared package mdu_pkg holds:
  - Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State encoding (S_IDLE, S_CALC, S_FIX, S_DONE).
  - Constants MDU_WIDTH=32 and MDU_ITERS=32.
- One natural sub-module: mdu_sign_fix, a combinational conditional two's-complement negate used for operand magnitude and result correction (64-bit and 32-bit instances).

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at edge N+33; HI=0xFFFFFFFE, LO=0x00000001; Busy high for 34 cycles.
- MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, DivByZero=0.
- DIVU A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF, DivByZero=1; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero cleared.
- MULTU 6*7 started, then Start with DIVU 9/3 pulsed at edge N+10 -> ignored; result HI=0, LO=42; Done pulses exactly once.
- Reset asserted asynchronously mid-CALC (edge N+15) -> Busy, Done, HI and LO drop to 0 immediately; Done never pulses; a new Start after release completes normally.
